alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Control front end that drives the combinational 32-bit ALU. It accepts one packed instruction per valid/ready handshake and decodes it. It reads operands from an internal 8x32 register file, drives the ALU's opcode and operand inputs, and waits a fixed latency. It then captures the ALU output, writes it back to the register file, and reports completion and errors.

Parameters:
ALU_LAT, 1, cycles the ALU operands are held stable before sampling for all ops except MUL/DIV (min 1)
MULDIV_LAT, 4, cycles held for opcode 2 (MUL) and 3 (DIV) (min 1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept an instruction
instr  input  32  [31:28] opcode, [27] imm_sel, [26:24] rd, [23:21] rs1, [20:18] rs2, [15:0] imm
alu_opcode  output  4  to ALU opcode
alu_data0  output  32  to ALU data0
alu_data1  output  32  to ALU data1
alu_out  input  32  from ALU out
done  output  1  one-cycle pulse when an instruction retires
result  output  32  last written-back value
err_illegal  output  1  one-cycle pulse on illegal opcode
err_div0  output  1  one-cycle pulse when DIV retires with data1 == 0

Behaviour:
- Reset is asynchronous and active-low and clears everything:
  - state = IDLE; all 8 registers = 0; alu_opcode = 0; alu_data0 = alu_data1 = 0
  - result = 0; done = err_illegal = err_div0 = 0; instr_ready = 1
- Opcode map (matches the ALU mux):
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 GT, 5 EQ, 6 LT
  - 8 AND, 9 OR, 10 XOR, 11 XNOR, 12 SHL, 13 SHR, 14 SRA
  - 7 and 15 are illegal.
- Register file:
  - r0 always reads 0; writes to r0 are discarded.
  - r1..r7 are 32-bit.
- Operands: data0 = R[rs1]. data1 = imm_sel ? {16'b0, imm} : R[rs2].
- FSM states IDLE, EXEC, WB:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready:
    - Legal opcode: register opcode, rd, data0 and data1 onto the alu_* outputs; load counter = (op 2/3 ? MULDIV_LAT : ALU_LAT) - 1; go to EXEC.
    - Illegal opcode: pulse err_illegal next cycle, no register write, alu_* unchanged, stay IDLE.
  - EXEC: instr_ready = 0; alu_* held constant. Counter decrements each cycle. When counter == 0, capture alu_out into the write-back latch and go to WB.
  - WB:
    - If rd != 0, write the latch to R[rd].
    - result <= latch; pulse done for 1 cycle.
    - Pulse err_div0 in the same cycle if op == 3 and data1 == 0; the value written is whatever the ALU produced.
    - Go to IDLE.
- Latency: accept edge -> done high after (LAT + 1) cycles. Throughput is one instruction per LAT + 2 cycles. instr_ready reasserts the cycle after WB.
- Hazards: operands are read at accept time. Write-back completes in WB before the next accept, so back-to-back dependent instructions see the updated value. No forwarding is required.
- instr_valid high while instr_ready = 0 is ignored. The instruction is not latched; the producer must hold it until accepted.
- Reset mid-EXEC or mid-WB aborts the instruction: no write, no done.
- alu_* outputs are registered and stay at their last value in IDLE.

Test Plan:
- Reset, then ADDI r1 = r0 + 5 (op0, imm_sel, imm = 5) followed by ADD r2 = r1 + r1 -> done after 2 cycles each; result 5 then 10; r2 = 10.
- MUL r3 = r2 * r1 with MULDIV_LAT = 4 -> alu_opcode = 2 held 4 cycles; done 5 cycles after accept; result 50.
- DIV r4 = r1 / r0 -> err_div0 pulses together with done; no hang; instr_ready returns next cycle.
- Opcode 7, then opcode 15 -> err_illegal pulses, no done, registers unchanged; the following ADD is accepted normally.
- Write to rd = 0 -> done pulses and result shows the value; a subsequent read of r0 gives 0.
- Assert reset_n low during EXEC of a MUL -> outputs are zero immediately; no done; all registers read 0 afterwards.

Source files
------------

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Front-end controller for a combinational 32-bit ALU. It accepts one packed
// instruction per valid/ready handshake and reads the operands from an
// internal 8x32 register file (r0 is hard-wired to zero). It drives the ALU
// inputs from registers and holds them for a fixed number of cycles. It then
// captures the ALU result and writes it back in a single WB cycle.
//
// Ports
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   instr_valid  instruction offered by the producer
//   instr_ready  high in IDLE; the sequencer can accept an instruction
//   instr        [31:28] opcode, [27] imm_sel, [26:24] rd, [23:21] rs1,
//                [20:18] rs2, [15:0] imm
//   alu_opcode   registered opcode to the ALU
//   alu_data0    registered operand 0 to the ALU (R[rs1])
//   alu_data1    registered operand 1 to the ALU (imm or R[rs2])
//   alu_out      combinational result from the ALU
//   done         one-cycle pulse when an instruction retires
//   result       last written-back value
//   err_illegal  one-cycle pulse after an illegal opcode is offered
//   err_div0     one-cycle pulse, together with done, for DIV by zero
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int ALU_LAT    = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  alu_opcode,
    output logic [31:0] alu_data0,
    output logic [31:0] alu_data1,
    input  logic [31:0] alu_out,
    output logic        done,
    output logic [31:0] result,
    output logic        err_illegal,
    output logic        err_div0
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] ALU_CNT    = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_LAT - 1);

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [3:0]        opcode_q,      opcode_d;
    logic [2:0]        rd_q,          rd_d;
    logic [31:0]       data0_q,       data0_d;
    logic [31:0]       data1_q,       data1_d;
    logic [31:0]       wb_q,          wb_d;
    logic [31:0]       result_q,      result_d;
    logic              done_q,        done_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_div0_q,    err_div0_d;
    logic [31:0]       rf_q [8];
    logic [31:0]       rf_d [8];

    // Instruction field decode
    logic [3:0]  in_op;
    logic        in_imm_sel;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic [15:0] in_imm;
    logic        in_legal;
    logic        in_muldiv;

    assign in_op      = instr[31:28];
    assign in_imm_sel = instr[27];
    assign in_rd      = instr[26:24];
    assign in_rs1     = instr[23:21];
    assign in_rs2     = instr[20:18];
    assign in_imm     = instr[15:0];
    // 7 and 15 are the two unused slots of the ALU mux
    assign in_legal   = (in_op != 4'd7) && (in_op != 4'd15);
    assign in_muldiv  = (in_op == OP_MUL) || (in_op == OP_DIV);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        opcode_d      = opcode_q;
        rd_d          = rd_q;
        data0_d       = data0_q;
        data1_d       = data1_q;
        wb_d          = wb_q;
        result_d      = result_q;
        done_d        = 1'b0;
        err_illegal_d = 1'b0;
        err_div0_d    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rf_d[i] = rf_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (in_legal) begin
                        opcode_d = in_op;
                        rd_d     = in_rd;
                        data0_d  = rf_q[in_rs1];
                        data1_d  = in_imm_sel ? {16'b0, in_imm} : rf_q[in_rs2];
                        cnt_d    = in_muldiv ? MULDIV_CNT : ALU_CNT;
                        state_d  = S_EXEC;
                    end else begin
                        // Rejected in place: ALU inputs and registers untouched
                        err_illegal_d = 1'b1;
                    end
                end
            end

            S_EXEC: begin
                if (cnt_q == '0) begin
                    wb_d    = alu_out;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_WB: begin
                rf_d[rd_q] = wb_q;
                result_d   = wb_q;
                done_d     = 1'b1;
                err_div0_d = (opcode_q == OP_DIV) && (data1_q == 32'd0);
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // r0 is hard-wired to zero; any write to it is dropped here
        rf_d[0] = 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            opcode_q      <= '0;
            rd_q          <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            wb_q          <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_div0_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            opcode_q      <= opcode_d;
            rd_q          <= rd_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            wb_q          <= wb_d;
            result_q      <= result_d;
            done_q        <= done_d;
            err_illegal_q <= err_illegal_d;
            err_div0_q    <= err_div0_d;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_opcode  = opcode_q;
    assign alu_data0   = data0_q;
    assign alu_data1   = data1_q;
    assign done        = done_q;
    assign result      = result_q;
    assign err_illegal = err_illegal_q;
    assign err_div0    = err_div0_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer (ALU_LAT = 1, MULDIV_LAT = 4). The bench
// contains a behavioural model of the combinational ALU. Each test task drives
// instructions and compares the observed outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int ALU_LAT    = 1;
    localparam int MULDIV_LAT = 4;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_data0;
    logic [31:0] alu_data1;
    logic [31:0] alu_out;
    logic        done;
    logic [31:0] result;
    logic        err_illegal;
    logic        err_div0;

    int tests_run;
    int tests_failed;

    typedef struct {
        int          lat;       // negedges from accept edge to first done
        int          busy;      // negedges with instr_ready low
        logic [3:0]  op;        // alu_opcode seen during first EXEC cycle
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] res;
        logic        dz;
        logic        ill;
        logic        done_after; // done one cycle after the pulse
    } obs_t;

    alu_sequencer #(
        .ALU_LAT    (ALU_LAT),
        .MULDIV_LAT (MULDIV_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_data0   (alu_data0),
        .alu_data1   (alu_data1),
        .alu_out     (alu_out),
        .done        (done),
        .result      (result),
        .err_illegal (err_illegal),
        .err_div0    (err_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; division by zero returns all ones
    always_comb begin
        alu_out = 32'd0;
        case (alu_opcode)
            4'd0:  alu_out = alu_data0 + alu_data1;
            4'd1:  alu_out = alu_data0 - alu_data1;
            4'd2:  alu_out = alu_data0 * alu_data1;
            4'd3:  alu_out = (alu_data1 == 32'd0) ? 32'hFFFF_FFFF : alu_data0 / alu_data1;
            4'd4:  alu_out = {31'd0, alu_data0 > alu_data1};
            4'd5:  alu_out = {31'd0, alu_data0 == alu_data1};
            4'd6:  alu_out = {31'd0, alu_data0 < alu_data1};
            4'd8:  alu_out = alu_data0 & alu_data1;
            4'd9:  alu_out = alu_data0 | alu_data1;
            4'd10: alu_out = alu_data0 ^ alu_data1;
            4'd11: alu_out = ~(alu_data0 ^ alu_data1);
            4'd12: alu_out = alu_data0 << alu_data1[4:0];
            4'd13: alu_out = alu_data0 >> alu_data1[4:0];
            4'd14: alu_out = $unsigned($signed(alu_data0) >>> alu_data1[4:0]);
            default: alu_out = 32'd0;
        endcase
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic is,
                                        input logic [2:0] rd, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic [15:0] imm);
        return {op, is, rd, rs1, rs2, 2'b00, imm};
    endfunction

    // Drives one instruction and records what the DUT does; no comparisons.
    task automatic do_instr(input logic [31:0] ins, output obs_t o);
        o = '{lat: 0, busy: 0, op: 4'h0, d0: 32'h0, d1: 32'h0, res: 32'h0,
              dz: 1'b0, ill: 1'b0, done_after: 1'b0};
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                o.op = alu_opcode;
                o.d0 = alu_data0;
                o.d1 = alu_data1;
            end
            if (done) begin
                o.lat = k;
                o.res = result;
                o.dz  = err_div0;
                o.ill = err_illegal;
                break;
            end
            if (!instr_ready) o.busy++;
        end
        @(negedge clk);
        o.done_after = done;
        $display("[TB] instr %h op %0d d0 %h d1 %h -> lat %0d result %h div0 %0b",
                 ins, o.op, o.d0, o.d1, o.lat, o.res, o.dz);
    endtask

    task automatic test_reset();
        tests_run++;
        if ({instr_ready, done, err_illegal, err_div0} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 1000", {instr_ready, done, err_illegal, err_div0});
        end
        tests_run++;
        if ({alu_opcode, alu_data0, alu_data1, result} !== 100'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got op %h d0 %h d1 %h res %h want all 0",
                     alu_opcode, alu_data0, alu_data1, result);
        end
    endtask

    task automatic test_add();
        obs_t o;
        do_instr(enc(4'd0, 1'b1, 3'd1, 3'd0, 3'd0, 16'd5), o);   // ADDI r1 = r0 + 5
        tests_run++;
        if (o.lat !== ALU_LAT + 2) begin
            tests_failed++;
            $display("FAIL addi_latency: got %0d want %0d", o.lat, ALU_LAT + 2);
        end
        tests_run++;
        if (o.res !== 32'd5 || o.d0 !== 32'd0 || o.d1 !== 32'd5) begin
            tests_failed++;
            $display("FAIL addi_result: got res %h d0 %h d1 %h want 5 0 5", o.res, o.d0, o.d1);
        end
        tests_run++;
        if (o.done_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL addi_done_pulse: got %b want 0", o.done_after);
        end
        do_instr(enc(4'd0, 1'b0, 3'd2, 3'd1, 3'd1, 16'd0), o);   // ADD r2 = r1 + r1
        tests_run++;
        if (o.res !== 32'd10 || o.lat !== ALU_LAT + 2) begin
            tests_failed++;
            $display("FAIL add_rr: got res %h lat %0d want 0000000a %0d", o.res, o.lat, ALU_LAT + 2);
        end
    endtask

    task automatic test_muldiv();
        obs_t o;
        do_instr(enc(4'd2, 1'b0, 3'd3, 3'd2, 3'd1, 16'd0), o);   // MUL r3 = r2 * r1
        tests_run++;
        if (o.lat !== MULDIV_LAT + 2 || o.busy !== MULDIV_LAT + 1) begin
            tests_failed++;
            $display("FAIL mul_latency: got lat %0d busy %0d want %0d %0d",
                     o.lat, o.busy, MULDIV_LAT + 2, MULDIV_LAT + 1);
        end
        tests_run++;
        if (o.res !== 32'd50 || o.op !== 4'd2) begin
            tests_failed++;
            $display("FAIL mul_result: got res %h op %0d want 00000032 2", o.res, o.op);
        end
        do_instr(enc(4'd3, 1'b0, 3'd5, 3'd3, 3'd1, 16'd0), o);   // DIV r5 = r3 / r1
        tests_run++;
        if (o.res !== 32'd10 || o.dz !== 1'b0 || o.lat !== MULDIV_LAT + 2) begin
            tests_failed++;
            $display("FAIL div_result: got res %h div0 %b lat %0d want 0000000a 0 %0d",
                     o.res, o.dz, o.lat, MULDIV_LAT + 2);
        end
        do_instr(enc(4'd3, 1'b0, 3'd4, 3'd1, 3'd0, 16'd0), o);   // DIV r4 = r1 / r0
        tests_run++;
        if (o.dz !== 1'b1 || o.res !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL div0: got div0 %b res %h want 1 ffffffff", o.dz, o.res);
        end
        tests_run++;
        if (err_div0 !== 1'b0 || instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL div0_recover: got div0 %b ready %b want 0 1", err_div0, instr_ready);
        end
    endtask

    task automatic test_logic();
        obs_t o;
        do_instr(enc(4'd10, 1'b1, 3'd6, 3'd3, 3'd0, 16'h000F), o); // XORI r6 = r3 ^ 0xF
        tests_run++;
        if (o.res !== 32'h0000_003D) begin
            tests_failed++;
            $display("FAIL xor_imm: got %h want 0000003d", o.res);
        end
        do_instr(enc(4'd4, 1'b0, 3'd7, 3'd2, 3'd1, 16'd0), o);     // GT r7 = r2 > r1
        tests_run++;
        if (o.res !== 32'd1) begin
            tests_failed++;
            $display("FAIL gt: got %h want 00000001", o.res);
        end
        do_instr(enc(4'd14, 1'b1, 3'd7, 3'd4, 3'd0, 16'd4), o);    // SRA r7 = r4 >>> 4
        tests_run++;
        if (o.res !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL sra: got %h want ffffffff", o.res);
        end
        do_instr(enc(4'd1, 1'b0, 3'd6, 3'd1, 3'd2, 16'd0), o);     // SUB r6 = r1 - r2
        tests_run++;
        if (o.res !== 32'hFFFF_FFFB || o.op !== 4'd1) begin
            tests_failed++;
            $display("FAIL sub: got res %h op %0d want fffffffb 1", o.res, o.op);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [3:0] bad_ops [2];
        bad_ops[0] = 4'd7;
        bad_ops[1] = 4'd15;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            instr       = enc(bad_ops[i], 1'b1, 3'd1, 3'd0, 3'd0, 16'd99);
            instr_valid = 1'b1;
            @(posedge clk);
            #1 instr_valid = 1'b0;
            @(negedge clk);
            $display("[TB] instr %h illegal -> err_illegal %b done %b ready %b op %0d",
                     instr, err_illegal, done, instr_ready, alu_opcode);
            tests_run++;
            if ({err_illegal, done, instr_ready} !== 3'b101 || alu_opcode !== 4'd1) begin
                tests_failed++;
                $display("FAIL illegal_%0d: got ill/done/rdy %b op %0d want 101 1",
                         bad_ops[i], {err_illegal, done, instr_ready}, alu_opcode);
            end
            @(negedge clk);
            tests_run++;
            if (err_illegal !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_pulse_%0d: got %b want 0", bad_ops[i], err_illegal);
            end
        end
        do_instr(enc(4'd0, 1'b0, 3'd7, 3'd1, 3'd2, 16'd0), o);     // ADD r7 = r1 + r2
        tests_run++;
        if (o.res !== 32'd15 || o.lat !== ALU_LAT + 2) begin
            tests_failed++;
            $display("FAIL after_illegal: got res %h lat %0d want 0000000f %0d", o.res, o.lat, ALU_LAT + 2);
        end
    endtask

    task automatic test_rd0();
        obs_t o;
        do_instr(enc(4'd0, 1'b1, 3'd0, 3'd1, 3'd0, 16'd7), o);     // ADDI r0 = r1 + 7
        tests_run++;
        if (o.res !== 32'd12 || o.lat !== ALU_LAT + 2) begin
            tests_failed++;
            $display("FAIL rd0_write: got res %h lat %0d want 0000000c %0d", o.res, o.lat, ALU_LAT + 2);
        end
        do_instr(enc(4'd9, 1'b0, 3'd7, 3'd0, 3'd0, 16'd0), o);     // OR r7 = r0 | r0
        tests_run++;
        if (o.d0 !== 32'd0 || o.d1 !== 32'd0 || o.res !== 32'd0) begin
            tests_failed++;
            $display("FAIL rd0_read: got d0 %h d1 %h res %h want 0 0 0", o.d0, o.d1, o.res);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        logic [31:0] r1;
        logic [31:0] r2;
        t1 = 0;
        t2 = 0;
        r1 = 32'h0;
        r2 = 32'h0;
        @(negedge clk);
        instr       = enc(4'd0, 1'b0, 3'd5, 3'd3, 3'd1, 16'd0);   // ADD r5 = r3 + r1
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr = enc(4'd1, 1'b0, 3'd6, 3'd5, 3'd1, 16'd0);     // SUB r6 = r5 - r1, held
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done && t1 == 0) begin
                t1 = k;
                r1 = result;
            end else if (done && t2 == 0) begin
                t2 = k;
                r2 = result;
                break;
            end
            if (k == t1 + 1 && t1 != 0) instr_valid = 1'b0;       // second accepted at this edge
        end
        instr_valid = 1'b0;
        $display("[TB] back_to_back -> first done %0d result %h, second done %0d result %h", t1, r1, t2, r2);
        tests_run++;
        if (t1 !== ALU_LAT + 2 || r1 !== 32'd55) begin
            tests_failed++;
            $display("FAIL b2b_first: got done %0d res %h want %0d 00000037", t1, r1, ALU_LAT + 2);
        end
        tests_run++;
        if (t2 !== 2 * ALU_LAT + 4 || r2 !== 32'd50) begin
            tests_failed++;
            $display("FAIL b2b_second: got done %0d res %h want %0d 00000032", t2, r2, 2 * ALU_LAT + 4);
        end
    endtask

    task automatic test_reset_mid_exec();
        obs_t o;
        int   dones;
        dones = 0;
        @(negedge clk);
        instr       = enc(4'd2, 1'b0, 3'd3, 3'd2, 3'd1, 16'd0);   // MUL r3 = r2 * r1
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        $display("[TB] reset mid-EXEC -> op %0d d0 %h res %h ready %b done %b",
                 alu_opcode, alu_data0, result, instr_ready, done);
        tests_run++;
        if ({alu_opcode, alu_data0, alu_data1, result} !== 100'd0 || instr_ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got op %h d0 %h d1 %h res %h rdy %b done %b want zeros rdy 1",
                     alu_opcode, alu_data0, alu_data1, result, instr_ready, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", dones);
        end
        do_instr(enc(4'd0, 1'b0, 3'd1, 3'd3, 3'd2, 16'd0), o);     // ADD r1 = r3 + r2
        tests_run++;
        if (o.d0 !== 32'd0 || o.d1 !== 32'd0 || o.res !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_regs_a: got d0 %h d1 %h res %h want 0 0 0", o.d0, o.d1, o.res);
        end
        do_instr(enc(4'd9, 1'b0, 3'd2, 3'd5, 3'd6, 16'd0), o);     // OR r2 = r5 | r6
        tests_run++;
        if (o.d0 !== 32'd0 || o.d1 !== 32'd0 || o.res !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_regs_b: got d0 %h d1 %h res %h want 0 0 0", o.d0, o.d1, o.res);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        instr_valid  = 1'b0;
        instr        = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_muldiv();
        test_logic();
        test_illegal();
        test_rd0();
        test_back_to_back();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
